if_stage: RTL
=============

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter WORD_LEN, default 32, sets the width of every address and data word.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-low (0 = reset).
REQ-005 freeze  input  1  downstream stall; when 1, the outputs to IF2ID shall hold.
REQ-006 branch_taken  input  1  redirect request from a later stage.
REQ-007 branch_addr  input  WORD_LEN  redirect target; bits [1:0] are ignored.
REQ-008 imem_req  output  1  instruction-memory request.
REQ-009 imem_addr  output  WORD_LEN  request address; always word-aligned.
REQ-010 imem_ack  input  1  memory accepted the request; imem_rdata is valid in the same cycle.
REQ-011 imem_rdata  input  WORD_LEN  instruction word.
REQ-012 PC  output  WORD_LEN  registered fetch address + 4, feeding IF2ID PC_in.
REQ-013 instruction  output  WORD_LEN  registered instruction, feeding IF2ID instruction_in.
REQ-014 valid  output  1  registered; 1 = instruction is real, 0 = bubble.
REQ-015 fetch_stall  output  1  combinational; 1 while waiting on memory (FETCH without ack, or DRAIN).

Function
REQ-016 State: pc_reg (next fetch address), FSM {FETCH, HOLD, DRAIN}, one-entry buffer (buf_pc, buf_instr).
REQ-017 FETCH: imem_req=1 and imem_addr=pc_reg; ack in the same cycle as req is legal (zero-wait).
REQ-018 DRAIN: imem_req=1 and imem_addr = the old outstanding address; HOLD: imem_req=0.
REQ-019 imem_req, once asserted, shall stay high with imem_addr stable until imem_ack.
REQ-020 FETCH, ack=1, branch=0, freeze=0: next cycle PC=pc_reg+4, instruction=imem_rdata, valid=1; pc_reg<=pc_reg+4.
REQ-021 FETCH, ack=1, branch=0, freeze=1: buffer<=(pc_reg+4, imem_rdata); pc_reg<=pc_reg+4; go to HOLD; outputs hold.
REQ-022 HOLD, freeze=0, branch=0: outputs<=buffer with valid=1; go to FETCH.
REQ-023 FETCH, ack=0, freeze=0: outputs<=bubble (instruction=0, valid=0, PC held).
REQ-024 freeze=1 in any state: PC, instruction and valid shall not change.
REQ-025 branch_taken=1 has priority over freeze and ack; pc_reg<={branch_addr[31:2],2'b00}.
REQ-026 Branch in FETCH with ack=1: rdata is discarded; stay in FETCH.
REQ-027 Branch in FETCH with ack=0: go to DRAIN.
REQ-028 Branch in HOLD: buffer is discarded; go to FETCH.
REQ-029 Branch in DRAIN: pc_reg is updated; stay in DRAIN.
REQ-030 DRAIN with ack=1: data is discarded; go to FETCH, which issues pc_reg next cycle.
REQ-031 Branch with freeze=0: outputs<=bubble in the same edge; branch with freeze=1: outputs hold, and no discarded word shall ever reach the outputs.
REQ-032 pc_reg+4 wraps modulo 2^WORD_LEN (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-033 Exactly one instruction shall be delivered per acked non-discarded request: no duplicates and no drops across freeze.

Reset
REQ-034 rst=0 at a rising edge: pc_reg=RESET_PC, state=FETCH, PC=0, instruction=0, valid=0, buffer cleared.
REQ-035 While rst=0: imem_req=0 and fetch_stall=0.
REQ-036 Reset mid-request shall abandon the outstanding request without waiting for ack.
REQ-037 First imem_req=1 with imem_addr=RESET_PC in the first cycle after rst returns to 1.

Verification
REQ-038 Zero-wait memory (ack tied 1, rdata=addr^32'hA5A5_0000), freeze=0, 4 cycles after reset -> PC sequence 4, 8, 12, 16, valid=1 each cycle, matching instructions.
REQ-039 Ack delayed 2 cycles per request -> imem_addr held, fetch_stall=1, two bubbles (valid=0) between instructions, no PC skipped.
REQ-040 freeze=1 for 3 cycles coinciding with an ack at addr 8 -> outputs frozen; after release PC=12 with the addr-8 word, then 16; no duplicate or lost word.
REQ-041 branch_taken with branch_addr=32'h0000_0103 while a request to 0x20 is outstanding -> DRAIN holds 0x20 until ack; word discarded; next request 0x100; next valid PC=0x104.
REQ-042 Branch during HOLD -> buffered word never appears; next fetch at the target.
REQ-043 RESET_PC=32'hFFFF_FFFC -> second request addr 0x0, output PC=0x0 then 0x4; rst=0 mid-wait -> outputs zeroed, restart at RESET_PC.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: issues word-aligned requests to instruction memory and
// registers the fetched word toward IF2ID, surviving downstream freezes and redirects.
module if_stage #(
   parameter int unsigned           WORD_LEN = 32,
   parameter logic [WORD_LEN-1:0]   RESET_PC = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                freeze,
   input  logic                branch_taken,
   input  logic [WORD_LEN-1:0] branch_addr,
   output logic                imem_req,
   output logic [WORD_LEN-1:0] imem_addr,
   input  logic                imem_ack,
   input  logic [WORD_LEN-1:0] imem_rdata,
   output logic [WORD_LEN-1:0] PC,
   output logic [WORD_LEN-1:0] instruction,
   output logic                valid,
   output logic                fetch_stall
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } fetchState_e;

   fetchState_e         state_q;
   logic [WORD_LEN-1:0] pc_q;
   logic [WORD_LEN-1:0] drainAddr_q;
   logic [WORD_LEN-1:0] bufPc_q;
   logic [WORD_LEN-1:0] bufInstr_q;
   logic [WORD_LEN-1:0] pcOut_q;
   logic [WORD_LEN-1:0] instr_q;
   logic                valid_q;

   logic [WORD_LEN-1:0] pcPlus4;
   logic [WORD_LEN-1:0] branchTarget;
   logic                deliver_d;
   logic [WORD_LEN-1:0] deliverPc_d;
   logic [WORD_LEN-1:0] deliverInstr_d;

   assign pcPlus4      = pc_q + WORD_LEN'(4);
   assign branchTarget = branch_addr & ~WORD_LEN'(3);

   // DRAIN keeps presenting the abandoned address so the handshake completes cleanly.
   assign imem_req    = rst && ((state_q == FETCH) || (state_q == DRAIN));
   assign imem_addr   = (state_q == DRAIN) ? drainAddr_q : pc_q;
   assign fetch_stall = rst && (((state_q == FETCH) && !imem_ack) || (state_q == DRAIN));

   always_comb begin
      deliver_d      = 1'b0;
      deliverPc_d    = pcPlus4;
      deliverInstr_d = imem_rdata;
      if (!branch_taken) begin
         if ((state_q == FETCH) && imem_ack) begin
            deliver_d = 1'b1;
         end else if (state_q == HOLD) begin
            deliver_d      = 1'b1;
            deliverPc_d    = bufPc_q;
            deliverInstr_d = bufInstr_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= FETCH;
         pc_q        <= RESET_PC;
         drainAddr_q <= '0;
         bufPc_q     <= '0;
         bufInstr_q  <= '0;
         pcOut_q     <= '0;
         instr_q     <= '0;
         valid_q     <= 1'b0;
      end else begin
         case (state_q)
            FETCH: begin
               if (branch_taken) begin
                  pc_q <= branchTarget;
                  if (!imem_ack) begin
                     drainAddr_q <= pc_q;
                     state_q     <= DRAIN;
                  end
               end else if (imem_ack) begin
                  pc_q <= pcPlus4;
                  if (freeze) begin
                     bufPc_q    <= pcPlus4;
                     bufInstr_q <= imem_rdata;
                     state_q    <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (branch_taken) begin
                  pc_q    <= branchTarget;
                  state_q <= FETCH;
               end else if (!freeze) begin
                  state_q <= FETCH;
               end
            end
            DRAIN: begin
               if (branch_taken) begin
                  pc_q <= branchTarget;
               end
               if (imem_ack) begin
                  state_q <= FETCH;
               end
            end
            default: state_q <= FETCH;
         endcase

         // Freeze holds the IF2ID-facing registers; anything not delivered becomes a bubble.
         if (!freeze) begin
            if (deliver_d) begin
               pcOut_q <= deliverPc_d;
               instr_q <= deliverInstr_d;
               valid_q <= 1'b1;
            end else begin
               instr_q <= '0;
               valid_q <= 1'b0;
            end
         end
      end
   end

   assign PC          = pcOut_q;
   assign instruction = instr_q;
   assign valid       = valid_q;

endmodule
